ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port `ram` block, which has a shared bidirectional data bus, a combinational read and a write on the clock edge.
- It serialises read/write requests from port 0 (instruction fetch) and port 1 (load/store) onto one RAM address/wen/data interface.
- It owns the tri-state drive of the RAM data bus so that bus contention cannot occur.
- It sits between the CPU core's memory stages and the `ram` instance.

Parameters:
- addr_width, 4, RAM address width; must match the `ram` instance.
- data_width, 4, RAM data width; must match the `ram` instance.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset; also wired to the RAM's rst_n.
- p0_req  input  1  port 0 request; held high with p0_addr/p0_wen/p0_wdata stable until p0_ack.
- p0_wen  input  1  port 0: 1 = write, 0 = read.
- p0_addr  input  addr_width  port 0 address.
- p0_wdata  input  data_width  port 0 write data.
- p0_ack  output  1  one-cycle completion pulse for port 0.
- p0_rdata  output  data_width  port 0 read data; valid while p0_ack=1.
- p1_req, p1_wen, p1_addr, p1_wdata, p1_ack, p1_rdata  same directions, widths and meaning for port 1.
- ram_addr  output  addr_width  to RAM addr.
- ram_wen  output  1  to RAM wen.
- ram_data  inout  data_width  to RAM data bus.
- busy  output  1  high in GRANT and DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, ram_wen=0, ram_addr=0, ram_data=Z.
  - p0_ack=p1_ack=0, p0_rdata=p1_rdata=0.
  - Priority pointer selects port 0. Latched request registers are cleared.
- FSM states: IDLE, GRANT, DONE. One state per cycle; each access takes 3 cycles.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port named by the priority pointer wins.
  - On the winning edge: latch winner id, addr, wen and wdata; drive ram_addr/ram_wen from the latch; go to GRANT.
- GRANT:
  - ram_addr and ram_wen hold the latched values.
  - ram_data is driven with the latched wdata only when latched wen=1; otherwise it is Z.
  - At the closing posedge:
    - Write: the RAM writes.
    - Read: the arbiter captures ram_data into the winner's rdata register.
  - Also at the closing posedge: ram_wen←0, winner ack←1, priority pointer←the other port; go to DONE.
- DONE:
  - Winner's ack=1 for exactly this cycle; rdata is valid (write: rdata is unchanged).
  - Requests are not sampled in DONE, so a held req is never re-granted.
  - Next edge: ack←0, go to IDLE.
- rdata registers hold their last value until the next read for that port.
- Bus rule: ram_data is driven only while ram_wen=1.
  - Both signals come from the same register, so the arbiter and the RAM never drive together.
  - At all other times ram_data=Z and the RAM drives mem[ram_addr].
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1…
  - The pointer changes only on a completed access.
- Request changes while not granted are allowed; only the values present at the IDLE grant edge are used.
- Reset asserted in GRANT aborts the access:
  - Bus goes Z immediately, no ack is issued, and the pointer returns to port 0.
  - The RAM also ignores the write because its rst_n is low.
- Addresses are not range-checked; the full 2^addr_width space is accessible, including address (1<<addr_width)-1.

Test Plan:
- Reset, then p0 read addr 3 (RAM preloaded mem[3]=4'b1010) → busy at cycle 1, p0_ack pulse at cycle 2 (counted from the grant edge) with p0_rdata=4'hA; p1_ack stays 0.
- p1 write addr 15 data 4'h5, then p1 read addr 15 → write ack, then read ack with p1_rdata=4'h5; ram_data is never X during the sequence.
- p0 and p1 request at the same edge (reads of addr 1 and 2), both held → p0 acked first, then p1; next simultaneous pair → p0 first again (pointer back to port 0 after serving p1).
- Both ports hold req for 6 accesses → ack order 0,1,0,1,0,1; each access spans exactly 3 cycles.
- p0 write addr 7 data 4'hF with rst_n pulsed low during GRANT → no p0_ack, ram_data=Z, ram_wen=0 while reset; a later read of addr 7 returns the original preload value.
- Requester keeps p0_req high one cycle past ack (DONE) → only one access is performed; a second grant occurs only if req is still high at the IDLE edge.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Request/acknowledge bundle between the CPU memory stages (master) and ram_arbiter (slave).
// Port 0 is instruction fetch, port 1 is load/store; both follow a req-held-until-ack protocol.
interface ram_arbiter_if #(
    parameter int addr_width = 4,
    parameter int data_width = 4
);
    logic                  p0_req;
    logic                  p0_wen;
    logic [addr_width-1:0] p0_addr;
    logic [data_width-1:0] p0_wdata;
    logic                  p0_ack;
    logic [data_width-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_wen;
    logic [addr_width-1:0] p1_addr;
    logic [data_width-1:0] p1_wdata;
    logic                  p1_ack;
    logic [data_width-1:0] p1_rdata;

    modport master (
        output p0_req, p0_wen, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_wen, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata
    );

    modport slave (
        input  p0_req, p0_wen, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_wen, p1_addr, p1_wdata,
        output p1_ack, p1_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer putting two requesters onto one single-port RAM; owns the data bus drive.
// Latency: 3 cycles per access (IDLE grant, GRANT, DONE with ack); requests are only sampled in IDLE.
module ram_arbiter #(
    parameter int addr_width = 4,
    parameter int data_width = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_if.slave          req_if,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_wen,
    inout  wire  [data_width-1:0] ram_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  win_q, win_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic                  ram_wen_q, ram_wen_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [data_width-1:0] rdata0_q, rdata0_d;
    logic [data_width-1:0] rdata1_q, rdata1_d;
    logic                  pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            ram_wen_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            ram_wen_q <= ram_wen_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        ram_wen_d = ram_wen_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        // Port 1 wins when it is the only requester or when the pointer favours it.
        pick1     = req_if.p1_req && (!req_if.p0_req || ptr_q);

        unique case (state_q)
            IDLE: begin
                if (req_if.p0_req || req_if.p1_req) begin
                    win_d     = pick1;
                    addr_d    = pick1 ? req_if.p1_addr  : req_if.p0_addr;
                    wen_d     = pick1 ? req_if.p1_wen   : req_if.p0_wen;
                    wdata_d   = pick1 ? req_if.p1_wdata : req_if.p0_wdata;
                    ram_wen_d = pick1 ? req_if.p1_wen   : req_if.p0_wen;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                ram_wen_d = 1'b0;
                if (!wen_q) begin
                    if (win_q) rdata1_d = ram_data;
                    else       rdata0_d = ram_data;
                end
                ack0_d  = !win_q;
                ack1_d  = win_q;
                ptr_d   = !win_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus drive and RAM write enable share one register, so only one side ever drives.
    assign ram_data        = ram_wen_q ? wdata_q : {data_width{1'bz}};
    assign ram_wen         = ram_wen_q;
    assign ram_addr        = addr_q;
    assign busy            = (state_q == GRANT) || (state_q == DONE);
    assign req_if.p0_ack   = ack0_q;
    assign req_if.p1_ack   = ack1_q;
    assign req_if.p0_rdata = rdata0_q;
    assign req_if.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM on the shared bus, transaction-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ram_addr;
    logic       ram_wen;
    wire  [3:0] ram_data;
    logic       busy;

    ram_arbiter_if #(.addr_width(4), .data_width(4)) bus ();

    ram_arbiter #(.addr_width(4), .data_width(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (bus),
        .ram_addr (ram_addr),
        .ram_wen  (ram_wen),
        .ram_data (ram_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: combinational read onto the bus, write on the edge.
    logic [3:0] tb_mem [16];
    logic       loaded = 1'b0;
    assign ram_data = ram_wen ? 4'bzzzz : tb_mem[ram_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 4'(i) ^ 4'h9;
            loaded <= 1'b1;
        end else if (rst_n && ram_wen) begin
            tb_mem[ram_addr] <= ram_data;
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Requester-side stimulus, one entry per port.
    logic       req_v   [2];
    logic       wen_v   [2];
    logic [3:0] addr_v  [2];
    logic [3:0] wdata_v [2];
    logic       acked   [2];

    // Reference model: memory contents, round-robin pointer and a countdown of the 3-cycle access.
    logic [3:0] ref_mem   [16];
    logic [3:0] exp_rdata [2];
    logic       exp_ack   [2];
    logic       exp_busy, exp_ram_wen, m_ptr, m_win, m_wen;
    logic [3:0] m_addr, m_wdata;
    int         cnt;

    task automatic model_reset();
        cnt = 0; m_ptr = 1'b0; exp_busy = 1'b0; exp_ram_wen = 1'b0;
        for (int p = 0; p < 2; p++) begin
            exp_ack[p] = 1'b0; exp_rdata[p] = 4'h0;
        end
    endtask

    task automatic model_edge();
        exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (cnt == 0) begin
            if (req_v[0] || req_v[1]) begin
                m_win = req_v[1] && (!req_v[0] || m_ptr);
                m_addr = addr_v[m_win]; m_wen = wen_v[m_win]; m_wdata = wdata_v[m_win];
                cnt = 2; exp_busy = 1'b1; exp_ram_wen = m_wen;
            end else begin
                exp_busy = 1'b0; exp_ram_wen = 1'b0;
            end
        end else if (cnt == 2) begin
            if (m_wen) ref_mem[m_addr] = m_wdata;
            else       exp_rdata[m_win] = ref_mem[m_addr];
            exp_ack[m_win] = 1'b1;
            m_ptr = !m_win;
            cnt = 1; exp_busy = 1'b1; exp_ram_wen = 1'b0;
        end else begin
            cnt = 0; exp_busy = 1'b0; exp_ram_wen = 1'b0;
        end
    endtask

    task automatic drive_ports();
        bus.p0_req = req_v[0]; bus.p0_wen = wen_v[0]; bus.p0_addr = addr_v[0]; bus.p0_wdata = wdata_v[0];
        bus.p1_req = req_v[1]; bus.p1_wen = wen_v[1]; bus.p1_addr = addr_v[1]; bus.p1_wdata = wdata_v[1];
    endtask

    // Called at a negedge: apply inputs, predict the next posedge, check at the following negedge.
    task automatic cycle();
        drive_ports();
        model_edge();
        @(negedge clk);
        check_eq("p0_ack", bus.p0_ack, exp_ack[0]);
        check_eq("p1_ack", bus.p1_ack, exp_ack[1]);
        check_eq("busy", busy, exp_busy);
        check_eq("ram_wen", ram_wen, exp_ram_wen);
        if (cnt == 2) begin
            check_eq("ram_addr", ram_addr, m_addr);
            if (m_wen) check_eq("ram_data_wr", ram_data, m_wdata);
        end
        if (exp_ack[0]) check_eq("p0_rdata", bus.p0_rdata, exp_rdata[0]);
        if (exp_ack[1]) check_eq("p1_rdata", bus.p1_rdata, exp_rdata[1]);
        acked[0] = bus.p0_ack; acked[1] = bus.p1_ack;
    endtask

    task automatic wait_ack(output int port, output int ncyc);
        port = -1; ncyc = 0;
        for (int i = 0; i < 12 && port < 0; i++) begin
            cycle();
            ncyc++;
            if (acked[0]) port = 0;
            else if (acked[1]) port = 1;
        end
        check_eq("ack_seen", int'(port >= 0), 1);
    endtask

    task automatic set_req(input int p, input logic wen, input logic [3:0] addr, input logic [3:0] wdata);
        req_v[p] = 1'b1; wen_v[p] = wen; addr_v[p] = addr; wdata_v[p] = wdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, n;
        for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i) ^ 4'h9;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 0; wen_v[i] = 0; addr_v[i] = 0; wdata_v[i] = 0; acked[i] = 0;
        end
        m_win = 0; m_wen = 0; m_addr = 0; m_wdata = 0;
        model_reset();
        drive_ports();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ram_wen", ram_wen, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_p0_ack", bus.p0_ack, 0);
        check_eq("rst_p1_ack", bus.p1_ack, 0);
        check_eq("rst_p0_rdata", bus.p0_rdata, 0);
        check_eq("rst_p1_rdata", bus.p1_rdata, 0);
        rst_n = 1'b1;

        // Single read of the preloaded word at address 3.
        set_req(0, 1'b0, 4'd3, 4'h0);
        wait_ack(p, n);
        check_eq("t1_port", p, 0);
        check_eq("t1_cycles", n, 2);
        check_eq("t1_rdata", bus.p0_rdata, 4'hA);
        req_v[0] = 0; cycle();

        // Write then read back the top address.
        set_req(1, 1'b1, 4'd15, 4'h5);
        wait_ack(p, n); check_eq("t2_wr_port", p, 1);
        req_v[1] = 0; cycle();
        set_req(1, 1'b0, 4'd15, 4'h0);
        wait_ack(p, n); check_eq("t2_rd_port", p, 1);
        check_eq("t2_rdata", bus.p1_rdata, 4'h5);
        req_v[1] = 0; cycle();

        // Two simultaneous pairs: port 0 first each time.
        for (int k = 0; k < 2; k++) begin
            set_req(0, 1'b0, 4'd1, 4'h0);
            set_req(1, 1'b0, 4'd2, 4'h0);
            wait_ack(p, n); check_eq("t3_first", p, 0);
            req_v[0] = 0;
            wait_ack(p, n); check_eq("t3_second", p, 1);
            check_eq("t3_second_cycles", n, 3);
            req_v[1] = 0; cycle();
        end

        // Continuous requests on both ports alternate.
        set_req(0, 1'b0, 4'd0, 4'h0);
        set_req(1, 1'b1, 4'd9, 4'h3);
        for (int i = 0; i < 6; i++) begin
            wait_ack(p, n);
            check_eq("t4_order", p, i % 2);
            check_eq("t4_cycles", n, (i == 0) ? 2 : 3);
        end
        req_v[0] = 0; req_v[1] = 0; cycle();

        // Reset during the GRANT of a write aborts it.
        set_req(0, 1'b1, 4'd7, 4'hF);
        cycle();
        rst_n = 1'b0;
        #1;
        check_eq("t5_ram_wen", ram_wen, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_bus_from_ram", ram_data, 4'h9);
        req_v[0] = 0;
        cycle();
        check_eq("t5_no_ack", bus.p0_ack, 0);
        rst_n = 1'b1;
        cycle();
        set_req(0, 1'b0, 4'd7, 4'h0);
        wait_ack(p, n);
        check_eq("t5_port", p, 0);
        check_eq("t5_mem7", bus.p0_rdata, 4'hE);
        req_v[0] = 0; cycle();

        // Req held through DONE only: a single access.
        set_req(0, 1'b0, 4'd5, 4'h0);
        wait_ack(p, n);
        cycle();
        req_v[0] = 0;
        cycle();
        check_eq("t6_no_regrant", busy, 0);
        // Req still high at the IDLE edge: a second grant.
        set_req(0, 1'b0, 4'd5, 4'h0);
        wait_ack(p, n);
        cycle();
        cycle();
        check_eq("t6_regrant", busy, 1);
        wait_ack(p, n);
        check_eq("t6_regrant_port", p, 0);
        req_v[0] = 0; cycle();

        // Randomized traffic on both ports.
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < 2; q++) begin
                if (acked[q]) begin
                    if ($urandom_range(3) != 0) req_v[q] = 1'b0;
                end else if (!req_v[q] && $urandom_range(1) == 1) begin
                    set_req(q, 1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
                end
            end
            cycle();
        end
        req_v[0] = 0; req_v[1] = 0;
        for (int i = 0; i < 4; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
